// File: rtl/regfile_mp.sv
// Multi-read-port integer register file with byte strobes, same-cycle write bypass
// and a sequential zero-initialisation engine that replaces per-register reset.
module regfile_mp #(
  parameter  int DATA_WIDTH = 32,
  parameter  int NUM_REGS   = 32,
  parameter  int NUM_RD     = 2,
  localparam int ADDR_W     = $clog2(NUM_REGS)
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         clear_i,
  input  logic                         we_i,
  input  logic [ADDR_W-1:0]            w_addr_i,
  input  logic [DATA_WIDTH/8-1:0]      w_strb_i,
  input  logic [DATA_WIDTH-1:0]        din_i,
  input  logic [NUM_RD*ADDR_W-1:0]     rd_addr_i,
  output logic [NUM_RD*DATA_WIDTH-1:0] dout_o,
  output logic                         init_busy_o
);

  localparam int              NB      = DATA_WIDTH / 8;
  localparam logic [0:0]      ST_INIT = 1'b0;
  localparam logic [0:0]      ST_RUN  = 1'b1;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(NUM_REGS - 1);

  logic [0:0]            state;
  logic [ADDR_W-1:0]     cnt;
  logic                  busy;
  logic                  wr_ok;
  logic [DATA_WIDTH-1:0] mem [1:NUM_REGS-1];

  // x0 and any address beyond the last register are not backed by storage.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (a != '0) && (a <= LAST);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] merge_lanes(
    input logic [DATA_WIDTH-1:0] old_v,
    input logic [DATA_WIDTH-1:0] new_v,
    input logic [NB-1:0]         strb
  );
    logic [DATA_WIDTH-1:0] r;
    r = old_v;
    for (int k = 0; k < NB; k++) begin
      if (strb[k]) r[8*k +: 8] = new_v[8*k +: 8];
    end
    return r;
  endfunction

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= ST_INIT;
      cnt   <= ADDR_W'(1);
    end else begin
      case (state)
        ST_INIT: begin
          if (cnt == LAST) state <= ST_RUN;
          cnt <= cnt + ADDR_W'(1);
        end
        ST_RUN: begin
          if (clear_i) begin
            state <= ST_INIT;
            cnt   <= ADDR_W'(1);
          end
        end
        default: begin
          state <= ST_INIT;
          cnt   <= ADDR_W'(1);
        end
      endcase
    end
  end

  assign busy        = (state == ST_INIT);
  assign init_busy_o = busy;
  assign wr_ok       = !busy && we_i && !clear_i && addr_ok(w_addr_i);

  // Storage has no reset; the init engine zeroes one entry per cycle instead.
  always_ff @(posedge clk_i) begin
    if (busy) begin
      mem[cnt] <= '0;
    end else if (wr_ok) begin
      mem[w_addr_i] <= merge_lanes(mem[w_addr_i], din_i, w_strb_i);
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0]     ra;
    logic [DATA_WIDTH-1:0] stored;
    logic [DATA_WIDTH-1:0] rdata;

    assign ra = rd_addr_i[p*ADDR_W +: ADDR_W];

    always_comb begin
      stored = '0;
      rdata  = '0;
      if (addr_ok(ra)) stored = mem[ra];
      if (!busy && addr_ok(ra)) begin
        rdata = (wr_ok && ra == w_addr_i) ? merge_lanes(stored, din_i, w_strb_i) : stored;
      end
    end

    assign dout_o[p*DATA_WIDTH +: DATA_WIDTH] = rdata;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised and directed bench for regfile_mp against a behavioural register model.
module tb_regfile_mp;

  localparam int N  = 32;
  localparam int R  = 3;
  localparam int N2 = 24;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear, we;
  logic [4:0]  waddr;
  logic [3:0]  strb;
  logic [31:0] din;
  logic [14:0] rd_addr;
  logic [95:0] dout;
  logic        busy;

  logic        b_clear, b_we;
  logic [4:0]  b_waddr;
  logic [3:0]  b_strb;
  logic [31:0] b_din;
  logic [9:0]  b_rd;
  logic [63:0] b_dout;
  logic        b_busy;

  int checks = 0;
  int errors = 0;
  int init_left;
  logic [31:0] mem_m [N];

  always #5 clk = ~clk;

  regfile_mp #(.DATA_WIDTH(32), .NUM_REGS(N), .NUM_RD(R)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .clear_i(clear), .we_i(we), .w_addr_i(waddr),
    .w_strb_i(strb), .din_i(din), .rd_addr_i(rd_addr), .dout_o(dout), .init_busy_o(busy)
  );

  regfile_mp #(.DATA_WIDTH(32), .NUM_REGS(N2), .NUM_RD(2)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .clear_i(b_clear), .we_i(b_we), .w_addr_i(b_waddr),
    .w_strb_i(b_strb), .din_i(b_din), .rd_addr_i(b_rd), .dout_o(b_dout), .init_busy_o(b_busy)
  );

  function automatic logic [31:0] merge_m(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] s);
    logic [31:0] r;
    r = old_v;
    for (int k = 0; k < 4; k++) if (s[k]) r[8*k +: 8] = new_v[8*k +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_rd(input int a);
    if (init_left > 0 || a == 0 || a >= N) return 32'h0;
    if (we && !clear && a == int'(waddr)) return merge_m(mem_m[a], din, strb);
    return mem_m[a];
  endfunction

  function automatic logic [31:0] port(input int p);
    logic [95:0] d;
    d = dout;
    return d[p*32 +: 32];
  endfunction

  function automatic int rd_of(input int p);
    logic [14:0] r;
    r = rd_addr;
    return int'(r[p*5 +: 5]);
  endfunction

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
    rd_addr = {a2, a1, a0};
  endtask

  task automatic set_wr(input logic w, input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    we = w; waddr = a; din = d; strb = s;
  endtask

  // Advance one clock and move the model to its post-edge state.
  task automatic tick();
    int nl;
    nl = init_left;
    if (init_left > 0) begin
      mem_m[N - init_left] = 32'h0;
      nl = init_left - 1;
    end else if (clear) begin
      nl = N - 1;
    end else if (we && waddr != 0) begin
      mem_m[waddr] = merge_m(mem_m[waddr], din, strb);
    end
    @(posedge clk);
    init_left = nl;
    #1;
  endtask

  task automatic start_init_model();
    init_left = N - 1;
    for (int i = 0; i < N; i++) mem_m[i] = 32'h0;
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0; clear = 1'b0; set_wr(1'b0, 5'd0, 32'h0, 4'h0); set_rd(5'd5, 5'd5, 5'd5);
    b_clear = 1'b0; b_we = 1'b0; b_waddr = '0; b_strb = '0; b_din = '0; b_rd = '0;
    #3;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %b exp 1", busy); end
    checks++;
    if (dout !== 96'h0) begin errors++; $display("FAIL reset_dout got %h exp 0", dout); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    start_init_model();
    n = 0;
    for (int c = 0; c < 40; c++) begin
      #2;
      if (busy === 1'b1) n++;
      checks++;
      if (busy !== (init_left > 0)) begin errors++; $display("FAIL init_busy_cyc%0d got %b exp %b", c, busy, init_left > 0); end
      checks++;
      if (busy === 1'b1 && dout !== 96'h0) begin errors++; $display("FAIL init_dout_cyc%0d got %h exp 0", c, dout); end
      tick();
    end
    checks++;
    if (n != N - 1) begin errors++; $display("FAIL init_len got %0d exp %0d", n, N - 1); end
    for (int a = 1; a < N; a++) begin
      set_rd(5'(a), 5'(a), 5'(a));
      #1;
      checks++;
      if (port(0) !== 32'h0 || port(2) !== 32'h0) begin
        errors++; $display("FAIL zero_x%0d got %h/%h exp 0", a, port(0), port(2));
      end
    end
  endtask

  task automatic test_bypass();
    set_wr(1'b1, 5'd7, 32'hDEADBEEF, 4'hF); set_rd(5'd7, 5'd0, 5'd1);
    #2;
    checks++;
    if (port(0) !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_x7 got %h exp deadbeef", port(0)); end
    tick();
    set_wr(1'b0, 5'd0, 32'h0, 4'h0);
    #2;
    checks++;
    if (port(0) !== 32'hDEADBEEF) begin errors++; $display("FAIL stored_x7 got %h exp deadbeef", port(0)); end
  endtask

  task automatic test_strobes();
    set_wr(1'b1, 5'd3, 32'h11223344, 4'hF); set_rd(5'd3, 5'd3, 5'd7);
    tick();
    set_wr(1'b1, 5'd3, 32'hAABBCCDD, 4'b0101);
    #2;
    checks++;
    if (port(0) !== 32'h11BB33DD || port(1) !== 32'h11BB33DD) begin
      errors++; $display("FAIL strobe_bypass got %h/%h exp 11bb33dd", port(0), port(1));
    end
    checks++;
    if (port(2) !== 32'hDEADBEEF) begin errors++; $display("FAIL strobe_other got %h exp deadbeef", port(2)); end
    tick();
    set_wr(1'b0, 5'd0, 32'h0, 4'h0);
    #2;
    checks++;
    if (port(0) !== 32'h11BB33DD) begin errors++; $display("FAIL strobe_stored got %h exp 11bb33dd", port(0)); end
    // Zero strobe is a no-op even with we asserted.
    set_wr(1'b1, 5'd3, 32'h0, 4'h0);
    tick();
    set_wr(1'b0, 5'd0, 32'h0, 4'h0);
    #2;
    checks++;
    if (port(0) !== 32'h11BB33DD) begin errors++; $display("FAIL strobe_zero got %h exp 11bb33dd", port(0)); end
  endtask

  task automatic test_x0();
    set_wr(1'b1, 5'd0, 32'hFFFFFFFF, 4'hF); set_rd(5'd0, 5'd0, 5'd0);
    #2;
    checks++;
    if (dout !== 96'h0) begin errors++; $display("FAIL x0_bypass got %h exp 0", dout); end
    tick();
    set_wr(1'b0, 5'd0, 32'h0, 4'h0);
    #2;
    checks++;
    if (port(1) !== 32'h0) begin errors++; $display("FAIL x0_stored got %h exp 0", port(1)); end
  endtask

  task automatic test_multiport();
    set_wr(1'b1, 5'd4, 32'h3, 4'hF);
    tick();
    set_wr(1'b0, 5'd0, 32'h0, 4'h0); set_rd(5'd4, 5'd4, 5'd4);
    #2;
    for (int p = 0; p < R; p++) begin
      checks++;
      if (port(p) !== 32'h3) begin errors++; $display("FAIL multiport_p%0d got %h exp 3", p, port(p)); end
    end
  endtask

  task automatic test_clear();
    int n;
    set_wr(1'b1, 5'd9, 32'h55, 4'hF);
    tick();
    clear = 1'b1; set_wr(1'b1, 5'd9, 32'h77, 4'hF); set_rd(5'd9, 5'd4, 5'd9);
    #2;
    checks++;
    if (port(0) !== 32'h55) begin errors++; $display("FAIL clear_cycle_read got %h exp 55", port(0)); end
    tick();
    clear = 1'b0;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      #2;
      if (busy === 1'b1) n++;
      checks++;
      if (busy !== (init_left > 0) || dout !== {exp_rd(9), exp_rd(4), exp_rd(9)}) begin
        errors++; $display("FAIL clear_cyc%0d busy %b dout %h exp busy %b dout %h", c, busy, dout,
                            init_left > 0, {exp_rd(9), exp_rd(4), exp_rd(9)});
      end
      set_wr(init_left > 0, 5'd9, 32'h77, 4'hF);
      tick();
    end
    set_wr(1'b0, 5'd0, 32'h0, 4'h0);
    checks++;
    if (n != N - 1) begin errors++; $display("FAIL clear_len got %0d exp %0d", n, N - 1); end
    #2;
    checks++;
    if (port(0) !== 32'h0 || port(1) !== 32'h0) begin errors++; $display("FAIL clear_after got %h/%h exp 0", port(0), port(1)); end
  endtask

  task automatic test_mid_reset();
    int n;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    start_init_model();
    for (int c = 0; c < 9; c++) tick();
    rst_n = 1'b0;
    #2;
    checks++;
    if (busy !== 1'b1 || dout !== 96'h0) begin errors++; $display("FAIL midreset_assert busy %b dout %h exp 1/0", busy, dout); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    start_init_model();
    n = 0;
    for (int c = 0; c < 40; c++) begin
      #2;
      if (busy === 1'b1) n++;
      tick();
    end
    checks++;
    if (n != N - 1) begin errors++; $display("FAIL midreset_len got %0d exp %0d", n, N - 1); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      set_wr($urandom_range(0, 1) == 1, 5'($urandom_range(0, N - 1)), $urandom, 4'($urandom_range(0, 15)));
      set_rd(5'($urandom_range(0, N - 1)), ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, N - 1)),
             5'($urandom_range(0, N - 1)));
      clear = ($urandom_range(0, 79) == 0);
      #2;
      checks++;
      if (busy !== (init_left > 0)) begin errors++; $display("FAIL rand_busy_c%0d got %b exp %b", c, busy, init_left > 0); end
      for (int p = 0; p < R; p++) begin
        checks++;
        if (port(p) !== exp_rd(rd_of(p))) begin
          errors++; $display("FAIL rand_c%0d_p%0d addr %0d got %h exp %h", c, p, rd_of(p), port(p), exp_rd(rd_of(p)));
        end
      end
      tick();
    end
    clear = 1'b0; set_wr(1'b0, 5'd0, 32'h0, 4'h0);
  endtask

  task automatic test_out_of_range();
    for (int c = 0; c < 60 && b_busy === 1'b1; c++) begin @(posedge clk); #1; end
    checks++;
    if (b_busy !== 1'b0) begin errors++; $display("FAIL oor_init_done got %b exp 0", b_busy); end
    b_we = 1'b1; b_waddr = 5'd6; b_din = 32'h12345678; b_strb = 4'hF;
    @(posedge clk); #1;
    b_waddr = 5'd30; b_din = 32'hFFFFFFFF; b_rd = {5'd6, 5'd30};
    #2;
    checks++;
    if (b_dout !== {32'h12345678, 32'h0}) begin errors++; $display("FAIL oor_bypass got %h exp 12345678_00000000", b_dout); end
    @(posedge clk); #1;
    b_we = 1'b0;
    #2;
    checks++;
    if (b_dout !== {32'h12345678, 32'h0}) begin errors++; $display("FAIL oor_stored got %h exp 12345678_00000000", b_dout); end
    b_we = 1'b1; b_waddr = 5'd23; b_din = 32'hCAFEF00D;
    @(posedge clk); #1;
    b_we = 1'b0; b_rd = {5'd24, 5'd23};
    #2;
    checks++;
    if (b_dout !== {32'h0, 32'hCAFEF00D}) begin errors++; $display("FAIL oor_edge got %h exp 00000000_cafef00d", b_dout); end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_strobes();
    test_x0();
    test_multiport();
    test_clear();
    test_mid_reset();
    test_random();
    test_out_of_range();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port integer register file for the processor datapath; the successor to the fixed 32x32, two-read-port register file. Adds write enable, byte-lane strobes, same-cycle write-to-read bypass, and a sequential zero-initialisation engine. The engine runs after reset and on request, so no per-register reset flops are needed. The block sits between decode (read addresses) and writeback (write port).

## Interface
- `DATA_WIDTH`, default 32, is the register width in bits. It must be a multiple of 8 and at least 8.
- `NUM_REGS`, default 32, is the number of architectural registers including x0. Range 2..256.
- `NUM_RD`, default 2, is the number of independent read ports. Range 1..4.
- `ADDR_W` is derived and is not user-overridable: `$clog2(NUM_REGS)`.
- `clk_i`, input, 1 bit: clock. All state updates on the rising edge.
- `rst_n_i`, input, 1 bit: reset, asynchronous, active-low.
- `clear_i`, input, 1 bit: synchronous request to re-zero all registers.
- `we_i`, input, 1 bit: write enable.
- `w_addr_i`, input, `ADDR_W` bits: write address.
- `w_strb_i`, input, `DATA_WIDTH/8` bits: byte-lane write strobes. Bit k covers `din_i[8k+7:8k]`.
- `din_i`, input, `DATA_WIDTH` bits: write data.
- `rd_addr_i`, input, `NUM_RD*ADDR_W` bits: packed read addresses. Port p uses `[p*ADDR_W +: ADDR_W]`.
- `dout_o`, output, `NUM_RD*DATA_WIDTH` bits: packed read data. Port p uses `[p*DATA_WIDTH +: DATA_WIDTH]`.
- `init_busy_o`, output, 1 bit: high while the initialisation engine is running.

## Operation
- **Storage:** registers 1..`NUM_REGS`-1 are held in an array with no reset.
- **Register 0:** hardwired to zero. Writes to it are discarded and reads of it return 0.
- **FSM states:**
  - INIT: the engine writes 0 to one register per cycle.
  - RUN: normal operation.
- **Reset:** asynchronous assertion of `rst_n_i` forces state=INIT, init counter=1 and `init_busy_o`=1.
- **INIT behaviour:**
  - Each cycle, `reg[cnt]` is set to 0 and cnt is incremented.
  - The cycle that writes `reg[NUM_REGS-1]` transitions to RUN.
  - User writes are ignored.
  - All `dout_o` ports read 0.
  - `clear_i` is ignored.
- **RUN + `clear_i`=1:** enter INIT with cnt=1 on the next edge. A `we_i` in the same cycle is dropped; clear wins.
- **RUN write:** when `we_i`=1, `w_addr_i` is in 1..`NUM_REGS`-1, and `clear_i`=0, each byte lane k with `w_strb_i[k]`=1 takes `din_i` lane k. Lanes with a 0 strobe keep their old value.
  - `w_strb_i`=0 is a legal no-op.
- **Read ports:** combinational and independent. Every port may read the same address in the same cycle.
- **Bypass:**
  - Applies when `we_i`=1 in RUN without `clear_i`, and `rd_addr_i[p]`==`w_addr_i`!=0.
  - Port p returns the strobe-merged new value: strobed lanes from `din_i`, other lanes from the stored register.
- **Out-of-range addresses:** any address >= `NUM_REGS`, possible when `NUM_REGS` is not a power of two.
  - Reads return 0.
  - Writes are discarded.
  - The bypass never matches an out-of-range write.
- **Reset mid-operation:**
  - An in-flight write is lost.
  - Stored contents are undefined until INIT completes.
  - Outputs read 0 throughout INIT.

## Timing
- **Reset values:**
  - `init_busy_o`=1.
  - `dout_o`=0 on all ports, for the entire INIT phase.
- **INIT duration:** exactly `NUM_REGS`-1 clock edges after `rst_n_i` deasserts or after the `clear_i` edge.
  - `init_busy_o` falls after the edge that clears the last register.
  - The first accepted write is in the cycle `init_busy_o` is observed low.
- **Write latency:** a write commits on the rising edge of its cycle.
  - With the bypass, a same-cycle read sees the new value.
  - A read in the following cycle sees it from storage.
- **Read latency:** 0 cycles, combinational from `rd_addr_i` to `dout_o`.
- **Back-to-back writes** to the same register on consecutive cycles each apply in order with their own strobes.

## Test plan
- **Reset/init:**
  - Stimulus: `NUM_REGS`=32; release reset and hold `rd_addr_i`=5.
  - Required: `init_busy_o` high for exactly 31 cycles, then low. `dout_o`=0 throughout.
  - Then read all registers: every register 1..31 reads 0.
- **Write/read with bypass:**
  - Stimulus: write x7=0xDEADBEEF with strobe 0xF while port0 reads x7.
  - Required: same cycle `dout_o[0]`=0xDEADBEEF. Next cycle, without writing, it still reads 0xDEADBEEF.
- **Byte strobes:**
  - Stimulus: x3=0x11223344, then write din=0xAABBCCDD with strobe 0b0101.
  - Required: x3 reads 0x11BB33DD. The bypass shows the same value in the write cycle.
- **x0 and out-of-range:**
  - Stimulus, x0: write x0=0xFFFFFFFF. Required: x0 reads 0.
  - Stimulus, out of range: `NUM_REGS`=24, write address 30, then read address 30. Required: reads 0, and x6 is unchanged.
- **Clear vs write:**
  - Stimulus: x9=0x55; then pulse `clear_i` together with `we_i` x9=0x77.
  - Required: `init_busy_o` high for `NUM_REGS`-1 cycles, writes during INIT are ignored, and x9 reads 0 afterwards.
- **Multi-port + mid-init reset:**
  - Stimulus, multi-port: `NUM_RD`=3, all ports read x4=0x3 simultaneously. Required: all ports return 0x3.
  - Stimulus, reset: assert `rst_n_i` while INIT is at cnt=10. Required: restart at cnt=1 and take the full 31 cycles again.
